ahb_slave_mem: RTL

//  AHB slave memory that sits directly downstream of the interconnect's address decoder/slave mux.
//  One instance serves one slave_number window; the window is taken from integration_pkg

---
 rtl/integration_pkg.sv | 25 ++
 rtl/ahb_byte_lanes.sv | 29 ++
 rtl/ahb_slave_mem.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/integration_pkg.sv
// Shared AHB types and the interconnect's slave address windows.
package integration_pkg;

  localparam int slave_number = 4;
  localparam int SLAVE_IDX_W  = $clog2(slave_number);

  // Inclusive byte windows; slave 3 is deliberately narrower than its memory.
  localparam logic [slave_number-1:0][31:0] slave_low_address  =
    {32'd96, 32'd64, 32'd32, 32'd0};
  localparam logic [slave_number-1:0][31:0] slave_high_address =
    {32'd126, 32'd95, 32'd63, 32'd31};

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} transfer_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} rw_t;
  typedef enum logic [2:0] {
    BYTE, HALFWORD, WORD, WORDx2, WORDx4, WORDx8, WORDx16, WORDx32
  } size_t;
  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
  } burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} resp_t;

  typedef enum bit [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

endpackage

// File: rtl/ahb_byte_lanes.sv
// Little-endian lane strobes and alignment check for BYTE/HALFWORD/WORD transfers.
module ahb_byte_lanes
  import integration_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       misalign_o
);

  // Oversized transfers get no lanes; they are rejected by the caller.
  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      BYTE:     strb_o = 4'b0001 << addr_i;
      HALFWORD: begin
        strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_i[0];
      end
      WORD: begin
        strb_o     = 4'b1111;
        misalign_o = |addr_i;
      end
      default: strb_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave memory for one decoder window: programmable wait states,
// two-cycle ERROR response, registered read data with write forwarding.
module ahb_slave_mem
  import integration_pkg::*;
#(
  parameter int SLAVE_ID    = 0,
  parameter int WAIT_STATES = 1,
  parameter int MEM_BYTES   = 32
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output state_t      dbg_state_o
);

  localparam int                AW    = $clog2(MEM_BYTES);
  localparam logic [SLAVE_IDX_W-1:0] SID = SLAVE_IDX_W'(SLAVE_ID);
  localparam logic [31:0]       LOW   = slave_low_address[SID];
  localparam logic [31:0]       SPAN  = slave_high_address[SID] - LOW;
  localparam logic [3:0]        WS_M1 = 4'(WAIT_STATES - 1);

  logic [7:0]    mem_q [MEM_BYTES];
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] off_q, off_d;
  logic [3:0]    strb_q, strb_d;
  logic          write_q, write_d;
  logic [31:0]   hrdata_q;
  logic          hreadyout_q;
  resp_t         hresp_q;

  logic [31:0] diff;
  logic        accept, err, misalign;
  logic [3:0]  strb;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0]};

  ahb_byte_lanes u_lanes (
    .size_i     (HSIZE),
    .addr_i     (HADDR[1:0]),
    .strb_o     (strb),
    .misalign_o (misalign)
  );

  // Unsigned wrap makes addresses below LOW fail the span test as well.
  always_comb begin
    diff    = HADDR - LOW;
    accept  = HSEL && HREADY && HTRANS[1];
    err     = (diff > SPAN) || (HSIZE > 3'd2) || misalign;
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    strb_d  = strb_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          off_d   = AW'(diff);
          strb_d  = strb;
          write_d = HWRITE;
          if (err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end else begin
            state_d = S_LAST;
          end
        end
      end
    endcase
  end

  // A write retiring on the edge that loads a read of the same word is forwarded.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem_q[{off_d[AW-1:2], 2'(i)}];
      if (state_q == S_LAST && write_q && strb_q[i] && off_q[AW-1:2] == off_d[AW-1:2])
        rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      strb_q      <= strb_d;
      write_q     <= write_d;
      hreadyout_q <= !(state_d inside {S_WAIT, S_ERR1});
      hresp_q     <= (state_d inside {S_ERR1, S_ERR2}) ? ERROR : OKAY;
      if (state_d == S_ERR1)
        hrdata_q <= '0;
      else if (state_d == S_LAST && !write_d)
        hrdata_q <= rd_word;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
    end else if (state_q == S_LAST && write_q) begin
      for (int i = 0; i < 4; i++)
        if (strb_q[i]) mem_q[{off_q[AW-1:2], 2'(i)}] <= HWDATA[8*i +: 8];
    end
  end

  assign HRDATA      = hrdata_q;
  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign dbg_state_o = state_q;

endmodule
